// File: rtl/alu_unit.sv
// Execute-stage 32-bit ALU: one-cycle logic/add/shift ops, 32-cycle iterative MUL/DIVU/REMU.
// Latency 1 cycle (single-cycle ops) or 32 cycles (iterative); start is ignored while busy.
module alu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, ITER} state_t;

  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  // MUL: work = {partial product, remaining multiplier bits}, d = multiplicand.
  // DIV: work = {remainder, quotient/dividend bits}, d = divisor (restoring).
  function automatic logic [63:0] iter_step(input logic is_mul, input logic [63:0] w,
                                            input logic [31:0] d);
    logic [32:0] sum;
    logic [32:0] trial;
    sum   = {1'b0, w[63:32]} + {1'b0, (w[0] ? d : 32'd0)};
    trial = w[63:31] - {1'b0, d};
    if (is_mul)
      return {sum, w[31:1]};
    else if (trial[32])
      return {w[62:0], 1'b0};
    else
      return {trial[31:0], w[30:0], 1'b1};
  endfunction

  logic        op_is_iter;
  logic [31:0] sum_w, diff_w, alu_res;
  logic        alu_ovf;
  logic [3:0]  cur_op;
  logic [63:0] step_in, step_out;
  logic [31:0] step_opnd, fin_res;

  assign op_is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign sum_w      = a + b;
  assign diff_w     = a - b;

  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (op)
      4'd0: begin
        alu_res = sum_w;
        alu_ovf = (a[31] == b[31]) && (sum_w[31] != a[31]);
      end
      4'd1: begin
        alu_res = diff_w;
        alu_ovf = (a[31] != b[31]) && (diff_w[31] != a[31]);
      end
      4'd2:    alu_res = a & b;
      4'd3:    alu_res = a | b;
      4'd4:    alu_res = a ^ b;
      4'd5:    alu_res = a << b[4:0];
      4'd6:    alu_res = a >> b[4:0];
      4'd7:    alu_res = {31'd0, $signed(a) < $signed(b)};
      default: alu_res = 32'd0;
    endcase
  end

  // The first iteration runs on the start edge, so 32 iterations finish at edge k+31.
  assign cur_op    = (state_q == IDLE) ? op : op_q;
  assign step_in   = (state_q == IDLE) ? ((op == OP_MUL) ? {32'd0, b} : {32'd0, a}) : work_q;
  assign step_opnd = (state_q == IDLE) ? ((op == OP_MUL) ? a : b) : opnd_q;
  assign step_out  = iter_step(cur_op == OP_MUL, step_in, step_opnd);
  assign fin_res   = (op_q == OP_REMU) ? step_out[63:32] : step_out[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_is_iter) begin
            state_d = ITER;
            op_d    = op;
            opnd_d  = step_opnd;
            work_d  = step_out;
            cnt_d   = 5'd1;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == 32'd0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      ITER: begin
        work_d = step_out;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = IDLE;
          cnt_d    = 5'd0;
          result_d = fin_res;
          zero_d   = (fin_res == 32'd0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      work_q   <= 64'd0;
      opnd_q   <= 32'd0;
      op_q     <= 4'd0;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == ITER);
  assign done   = done_q;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: latency-level reference model checked every cycle plus directed literal vectors.
module tb_alu_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        zero, ovf, busy, done;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  alu_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation table.
  task automatic ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z, output logic v);
    r = 32'd0;
    v = 1'b0;
    case (o)
      4'd0: begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
      4'd1: begin r = x - y; v = (x[31] != y[31]) && (r[31] != x[31]); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << y[4:0];
      4'd6: r = x >> y[4:0];
      4'd7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8: r = x * y;
      4'd9: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd10: r = (y == 0) ? x : x % y;
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endtask

  // Model: iterative ops complete 31 edges after the accepting edge.
  logic [31:0] m_res = 0, p_res = 0;
  logic        m_z = 0, m_o = 0, m_busy = 0, m_done = 0, p_z = 0, p_o = 0;
  int          m_left = 0;

  always @(posedge clk) begin
    logic [31:0] r;
    logic        z, v;
    if (reset) begin
      m_res = 0; m_z = 0; m_o = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_res = p_res; m_z = p_z; m_o = p_o;
        end
      end else if (start) begin
        ref_op(op, a, b, r, z, v);
        if (op >= 4'd8 && op <= 4'd10) begin
          m_left = 31; p_res = r; p_z = z; p_o = v;
        end else begin
          m_done = 1; m_res = r; m_z = z; m_o = v;
        end
      end
    end
    m_busy = (m_left != 0);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_result", result, m_res);
      chk("cyc_zero", {31'd0, zero}, {31'd0, m_z});
      chk("cyc_ovf", {31'd0, ovf}, {31'd0, m_o});
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, m_done});
    end
  end

  task automatic do_op(input string nm, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] er, input logic ez,
                       input logic eo, input int elat);
    int cyc;
    bit saw_busy;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    saw_busy = busy;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, cyc, elat);
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    if (elat == 1) chk({nm, "_nobusy"}, {31'd0, saw_busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int done_at;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, zero, ovf, busy, done}, 32'd0);

    do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1);
    do_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    do_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    do_op("srl_31", 4'd6, 32'h8000_0000, 32'h0000_001F, 32'd1, 1'b0, 1'b0, 1);
    do_op("undef12", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0, 1);
    do_op("sll_4", 4'd5, 32'h0000_00F1, 32'd4, 32'h0000_0F10, 1'b0, 1'b0, 1);
    do_op("xor", 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1'b0, 1'b0, 1);
    do_op("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    do_op("mul_wrap", 4'd8, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 32);
    do_op("mul_small", 4'd8, 32'd123, 32'd456, 32'd56088, 1'b0, 1'b0, 32);
    do_op("divu", 4'd9, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 32);
    do_op("remu", 4'd10, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 32);
    do_op("divu_by0", 4'd9, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    do_op("remu_by0", 4'd10, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 32);
    do_op("divu_big", 4'd9, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1'b0, 1'b0, 32);

    // Back-to-back single-cycle ops: done stays high with a fresh result each cycle.
    @(negedge clk);
    start = 1'b1; op = 4'd0; a = 32'd10; b = 32'd20;
    @(negedge clk);
    chk("b2b_add", result, 32'd30);
    chk("b2b_done1", {31'd0, done}, 32'd1);
    op = 4'd3; a = 32'hF0; b = 32'h0F;
    @(negedge clk);
    chk("b2b_or", result, 32'hFF);
    chk("b2b_done2", {31'd0, done}, 32'd1);
    op = 4'd2; a = 32'hF0; b = 32'h0F;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_and", result, 32'd0);
    chk("b2b_zero", {31'd0, zero}, 32'd1);

    // MUL with a start pulse and operand changes while busy.
    @(negedge clk);
    start = 1'b1; op = 4'd8; a = 32'd123; b = 32'd456;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; done_at = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin ndone++; done_at = cyc; end
      if (cyc == 4) begin start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2; end
      if (cyc == 5) start = 1'b0;
      if (cyc == 9) begin a = 32'd5; b = 32'd7; end
      @(negedge clk);
    end
    chk("intf_ndone", ndone, 32'd1);
    chk("intf_done_at", done_at, 32'd32);
    chk("intf_result", result, 32'd56088);

    // Reset in the middle of a divide abandons it.
    @(negedge clk);
    start = 1'b1; op = 4'd9; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 12; cyc++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags", {28'd0, zero, ovf, busy, done}, 32'd0);
    ndone = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("midrst_nodone", ndone, 32'd0);
    do_op("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_unit.md
# alu_unit

Execute-stage ALU for the 32-bit datapath. Takes operand A from register-file read port 1 and operand B from the operand-select mux output (register read data 2 or zero-extended 16-bit immediate), and produces a registered result with zero and overflow flags. Logic and add/shift ops complete in one cycle. Multiply, divide and remainder run iteratively over 32 cycles under a start/busy/done handshake that the control unit uses to stall the pipeline.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request an operation; sampled only when idle.
- op  input  4  operation code (see Operation).
- a  input  32  operand A (register read data 1).
- b  input  32  operand B (output of the operand-select mux).
- result  output  32  registered result; holds its value until the next done.
- zero  output  1  registered; 1 when result == 0, updated with result.
- ovf  output  1  registered; signed overflow for ADD/SUB, otherwise 0.
- busy  output  1  1 while an iterative op is in progress.
- done  output  1  one-cycle pulse; result/zero/ovf are valid and newly written.

## Operation
- States: IDLE, ITER.
- In IDLE, start=1 latches op/a/b at that edge.
- Single-cycle ops, written at the start edge, state stays IDLE:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: a << b[4:0]
  - 6 SRL: a >> b[4:0], logical
  - 7 SLT: signed a<b gives 1, else 0
- Iterative ops, enter ITER:
  - 8 MUL: low 32 bits of unsigned a×b, shift-add, one bit per cycle.
  - 9 DIVU: unsigned quotient, restoring division, one bit per cycle.
  - 10 REMU: unsigned remainder, same datapath as DIVU.
- Codes 11–15: result=0, zero=1, ovf=0, single-cycle done.
- ovf:
  - ADD: (a[31]==b[31]) && (sum[31]!=a[31]).
  - SUB: (a[31]!=b[31]) && (diff[31]!=a[31]).
  - All other ops: 0.
- ITER datapath:
  - 5-bit iteration counter, 0..31.
  - 64-bit work register for the partial product, or the remainder:quotient pair.
  - Latched copy of the operand.
  - On counter==31, the final iteration writes result/zero/ovf, pulses done and returns to IDLE.
- Divide by zero (b==0) is not special-cased. The algorithm runs its full 32 cycles and naturally yields quotient 0xFFFFFFFF and remainder a.
- start while busy is ignored; no queuing.
- a, b and op changes during ITER have no effect.
- start in the cycle done is high is legal (state is already IDLE) and is accepted.
- Reset, including mid-ITER, forces the following and abandons the operation with no done:
  - state=IDLE, counter=0
  - result=0, zero=0, ovf=0
  - busy=0, done=0

## Timing
- Reset values: result=0x00000000, zero=0, ovf=0, busy=0, done=0.
- Single-cycle op, start sampled at edge k: after edge k, done=1 with result valid; done=0 after edge k+1 unless another start.
- Iterative op, start sampled at edge k:
  - busy=1 after edges k..k+30.
  - Final iteration at edge k+31.
  - After edge k+31: busy=0, done=1, result valid.
  - Latency: 32 cycles, start to done.
- busy and done are never high together.
- result/zero/ovf change only on a done edge or on reset.
- Back-to-back single-cycle ops give done high continuously, with a new result each cycle.

## Test plan
- Reset then idle: all outputs 0. ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, ovf=1, zero=0, done one cycle after start, busy never high.
- SUB a=5, b=5 -> result 0, zero=1, ovf=0. SLT a=0xFFFFFFFF, b=1 -> result 1. SRL a=0x80000000, b=0x0000001F -> result 1. Undefined op 12 -> result 0, zero=1.
- MUL a=0x00010000, b=0x00010000 -> result 0, zero=1, done exactly 32 cycles after start. MUL a=123, b=456 -> result 56088.
- DIVU a=100, b=7 -> result 14. REMU a=100, b=7 -> result 2. DIVU a=9, b=0 -> result 0xFFFFFFFF. REMU a=9, b=0 -> result 9. Each op: done after 32 cycles.
- Start MUL, pulse start with an ADD at cycle 5 and change a/b at cycle 10 -> ADD ignored, MUL result unchanged, single done at cycle 32.
- Start DIVU, assert reset at cycle 12 -> after that edge all outputs 0, no done. A following ADD 2+3 -> result 5 with done one cycle after start.
